// File: rtl/dfp_pkg.sv
// Shared constants, mantissa types and the alignment FSM state for the
// decimal floating-point datapath.
package dfp_pkg;

    localparam int NDIG    = 32'd7;
    localparam int EXP_W   = 32'd8;
    localparam int GR_DIG  = 32'd2;
    localparam int DIG_W   = 32'd4;
    localparam int XDIG    = NDIG + GR_DIG;
    localparam int CNT_W   = $clog2(XDIG + 32'd1);
    localparam int MANT_W  = DIG_W * NDIG;
    localparam int XMANT_W = DIG_W * XDIG;

    typedef logic [MANT_W-1:0]  bcd_mant_t;
    typedef logic [XMANT_W-1:0] ext_mant_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } align_state_t;

    // Digit shift needed to align the exponents; the difference is taken one
    // bit wider than the exponents so it never wraps, then saturated.
    function automatic logic [CNT_W-1:0] align_count(input logic [EXP_W-1:0] ea,
                                                     input logic [EXP_W-1:0] eb);
        logic [EXP_W:0] diff;
        if (ea >= eb) begin
            diff = {1'b0, ea} - {1'b0, eb};
        end else begin
            diff = {1'b0, eb} - {1'b0, ea};
        end
        if (diff >= (EXP_W+1)'(XDIG)) begin
            return CNT_W'(XDIG);
        end else begin
            return diff[CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/digit_shr_sticky.sv
// Combinational right shift by a whole number of BCD digits; sticky reports
// whether any nonzero digit was shifted out.
module digit_shr_sticky
    import dfp_pkg::*;
#(
    parameter int N_DIG    = XDIG,
    parameter int CNT_BITS = CNT_W
) (
    input  logic [DIG_W*N_DIG-1:0] din,
    input  logic [CNT_BITS-1:0]    count,
    output logic [DIG_W*N_DIG-1:0] dout,
    output logic                   sticky
);

    // Digit i moves down to i-count; digits below count fold into sticky
    always_comb begin
        dout   = '0;
        sticky = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (i < int'(count)) begin
                sticky = sticky | (din[i*DIG_W +: DIG_W] != {DIG_W{1'b0}});
            end else begin
                dout[(i - int'(count))*DIG_W +: DIG_W] = din[i*DIG_W +: DIG_W];
            end
        end
    end

endmodule

// File: rtl/operand_align.sv
// Aligns two BCD operands to the larger exponent and appends G/R digits plus sticky.
// Build option OPERAND_ALIGN_FAST_SHIFT_EN replaces the digit-serial SHIFT state with a one-cycle barrel shift.
module operand_align
    import dfp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] E1,
    input  logic [EXP_W-1:0] E2,
    input  bcd_mant_t        M1,
    input  bcd_mant_t        M2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] E_out,
    output ext_mant_t        M1_out,
    output ext_mant_t        M2_out,
    output logic             sticky,
    output logic             shift_sel
);

    align_state_t     state_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             sticky_r;
    logic             shift_sel_r;
    logic [EXP_W-1:0] e_out_r;
    ext_mant_t        m1_r;
    ext_mant_t        m2_r;

    logic             e2_gt_s;
    logic [CNT_W-1:0] cnt_init_s;
    ext_mant_t        ext1_s;
    ext_mant_t        ext2_s;
    ext_mant_t        shr_in_s;
    ext_mant_t        shr_out_s;
    logic [CNT_W-1:0] shr_cnt_s;
    logic             shr_sticky_s;
`ifndef OPERAND_ALIGN_FAST_SHIFT_EN
    logic [CNT_W-1:0] cnt_r;
    logic             sel_zero_s;
`endif

    assign e2_gt_s    = (E2 > E1);
    assign cnt_init_s = align_count(E1, E2);
    assign ext1_s     = {M1, {(DIG_W*GR_DIG){1'b0}}};
    assign ext2_s     = {M2, {(DIG_W*GR_DIG){1'b0}}};

`ifdef OPERAND_ALIGN_FAST_SHIFT_EN
    // Full alignment straight from the input operands at accept time
    assign shr_in_s  = e2_gt_s ? ext1_s : ext2_s;
    assign shr_cnt_s = cnt_init_s;
`else
    // One digit per cycle from whichever register holds the smaller operand
    assign shr_in_s   = shift_sel_r ? m1_r : m2_r;
    assign shr_cnt_s  = CNT_W'(1'b1);
    assign sel_zero_s = (shr_in_s == '0);
`endif

    digit_shr_sticky #(
        .N_DIG   (XDIG),
        .CNT_BITS(CNT_W)
    ) u_shr (
        .din   (shr_in_s),
        .count (shr_cnt_s),
        .dout  (shr_out_s),
        .sticky(shr_sticky_s)
    );

    // Handshake FSM together with every result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            e_out_r     <= {EXP_W{1'b0}};
            m1_r        <= '0;
            m2_r        <= '0;
            sticky_r    <= 1'b0;
            shift_sel_r <= 1'b0;
`ifndef OPERAND_ALIGN_FAST_SHIFT_EN
            cnt_r       <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        e_out_r     <= e2_gt_s ? E2 : E1;
                        shift_sel_r <= e2_gt_s;
                        in_ready_r  <= 1'b0;
`ifdef OPERAND_ALIGN_FAST_SHIFT_EN
                        m1_r        <= e2_gt_s ? shr_out_s : ext1_s;
                        m2_r        <= e2_gt_s ? ext2_s : shr_out_s;
                        sticky_r    <= shr_sticky_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
`else
                        m1_r        <= ext1_s;
                        m2_r        <= ext2_s;
                        sticky_r    <= 1'b0;
                        cnt_r       <= cnt_init_s;
                        if (cnt_init_s == {CNT_W{1'b0}}) begin
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            state_r     <= ST_SHIFT;
                        end
`endif
                    end
                end
`ifndef OPERAND_ALIGN_FAST_SHIFT_EN
                ST_SHIFT: begin
                    // Nothing left to shift out: remaining shifts cannot change anything
                    if (sel_zero_s) begin
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        if (shift_sel_r) begin
                            m1_r <= shr_out_s;
                        end else begin
                            m2_r <= shr_out_s;
                        end
                        sticky_r <= sticky_r | shr_sticky_s;
                        cnt_r    <= cnt_r - CNT_W'(1'b1);
                        if (cnt_r == CNT_W'(1'b1)) begin
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign E_out     = e_out_r;
    assign M1_out    = m1_r;
    assign M2_out    = m2_r;
    assign sticky    = sticky_r;
    assign shift_sel = shift_sel_r;

endmodule

// File: tb/tb_operand_align.sv
// Randomised self-checking bench for operand_align against a digit-arithmetic
// reference model; honours OPERAND_ALIGN_FAST_SHIFT_EN for the expected latency.
module tb_operand_align;
    import dfp_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] E1;
    logic [EXP_W-1:0] E2;
    bcd_mant_t        M1;
    bcd_mant_t        M2;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] E_out;
    ext_mant_t        M1_out;
    ext_mant_t        M2_out;
    logic             sticky;
    logic             shift_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    operand_align dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .E1       (E1),
        .E2       (E2),
        .M1       (M1),
        .M2       (M2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .E_out    (E_out),
        .M1_out   (M1_out),
        .M2_out   (M2_out),
        .sticky   (sticky),
        .shift_sel(shift_sel)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: align by plain integer shifting of the 9-digit extended mantissa
    function automatic void ref_align(input logic [EXP_W-1:0] e1, input logic [EXP_W-1:0] e2,
                                      input bcd_mant_t m1, input bcd_mant_t m2,
                                      output logic [EXP_W-1:0] eo, output ext_mant_t r1,
                                      output ext_mant_t r2, output logic st, output logic sel,
                                      output int lat);
        longint unsigned a1, a2, x, mask;
        int d, k, s;
        a1   = longint'({m1, 8'h00});
        a2   = longint'({m2, 8'h00});
        sel  = (e2 > e1);
        eo   = sel ? e2 : e1;
        d    = sel ? (int'(e2) - int'(e1)) : (int'(e1) - int'(e2));
        k    = (d > XDIG) ? XDIG : d;
        x    = sel ? a1 : a2;
        mask = (64'd1 << (4 * k)) - 64'd1;
        st   = ((x & mask) != 64'd0);
        s    = 0;
        for (int p = 0; p < XDIG; p++) begin
            if (((x >> (4 * p)) & 64'hF) != 64'd0) s = p + 1;
        end
        x  = x >> (4 * k);
        r1 = sel ? ext_mant_t'(x) : ext_mant_t'(a1);
        r2 = sel ? ext_mant_t'(a2) : ext_mant_t'(x);
`ifdef OPERAND_ALIGN_FAST_SHIFT_EN
        lat = 1;
`else
        // k digit steps, unless the operand empties first (one more cycle to notice)
        if (k == 0)      lat = 1;
        else if (k <= s) lat = 1 + k;
        else             lat = 2 + s;
`endif
    endfunction

    function automatic bcd_mant_t rand_bcd();
        bcd_mant_t m = '0;
        if ($urandom_range(0, 7) == 0) return m;
        for (int i = 0; i < NDIG; i++) m[i*DIG_W +: DIG_W] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 3) == 0) m = m >> (DIG_W * $urandom_range(1, NDIG - 1));
        return m;
    endfunction

    task automatic scramble_inputs();
        E1 = 8'($urandom);
        E2 = 8'($urandom);
        M1 = rand_bcd();
        M2 = rand_bcd();
    endtask

    task automatic run_txn(input logic [EXP_W-1:0] e1, input logic [EXP_W-1:0] e2,
                           input bcd_mant_t m1, input bcd_mant_t m2,
                           input int hold, input bit pulse);
        logic [EXP_W-1:0] x_e;
        ext_mant_t        x_m1, x_m2;
        logic             x_st, x_sel;
        int               x_lat, waited, lat;
        ref_align(e1, e2, m1, m2, x_e, x_m1, x_m2, x_st, x_sel, x_lat);
        waited = 0;
        while (!in_ready && waited < 30) begin
            step();
            waited++;
        end
        check_val("in_ready_idle", in_ready, 64'd1);
        E1 = e1; E2 = e2; M1 = m1; M2 = m2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        scramble_inputs();
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check_val("latency", 64'(lat), 64'(x_lat));
        check_val("e_out", E_out, x_e);
        check_val("m1_out", M1_out, x_m1);
        check_val("m2_out", M2_out, x_m2);
        check_val("sticky", sticky, x_st);
        check_val("shift_sel", shift_sel, x_sel);
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                scramble_inputs();
                in_valid = 1'b1;
            end
            step();
            check_val("hold_valid", out_valid, 64'd1);
            check_val("hold_in_ready", in_ready, 64'd0);
            check_val("hold_m1", M1_out, x_m1);
            check_val("hold_m2", M2_out, x_m2);
            check_val("hold_sticky", sticky, x_st);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("release_valid", out_valid, 64'd0);
        check_val("release_in_ready", in_ready, 64'd1);
    endtask

    task automatic reset_check(input string tag);
        check_val({tag, "_in_ready"}, in_ready, 64'd1);
        check_val({tag, "_out_valid"}, out_valid, 64'd0);
        check_val({tag, "_e_out"}, E_out, 64'd0);
        check_val({tag, "_m1"}, M1_out, 64'd0);
        check_val({tag, "_m2"}, M2_out, 64'd0);
        check_val({tag, "_sticky"}, sticky, 64'd0);
        check_val({tag, "_shift_sel"}, shift_sel, 64'd0);
    endtask

    initial begin
        logic [EXP_W-1:0] e1, e2;
        int               delta;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        E1 = 8'h00; E2 = 8'h00; M1 = '0; M2 = '0;
        step();
        step();
        rst = 1'b0;
        reset_check("reset");

        run_txn(8'h45, 8'h43, 28'h1234567, 28'h7654321, 0, 1'b0);
        run_txn(8'h10, 8'h10, 28'h9999999, 28'h0000001, 1, 1'b0);
        run_txn(8'h20, 8'h40, 28'h1000000, 28'h1234567, 0, 1'b0);
        run_txn(8'h20, 8'h40, 28'h0000000, 28'h1234567, 0, 1'b0);
        run_txn(8'h33, 8'h30, 28'h5000001, 28'h0000090, 5, 1'b1);
        run_txn(8'h00, 8'hFF, 28'h0000305, 28'h8000000, 0, 1'b0);
        run_txn(8'h09, 8'h00, 28'h1111111, 28'h9000000, 0, 1'b0);
        run_txn(8'h08, 8'h00, 28'h1111111, 28'h9000000, 0, 1'b0);

        // Abort in the middle of a long shift; the pair must be dropped
        E1 = 8'h40; E2 = 8'h38; M1 = 28'h1234567; M2 = 28'h9876543;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_check("abort");
        for (int i = 0; i < 12; i++) step();
        check_val("abort_no_result", out_valid, 64'd0);

        for (int n = 0; n < 40; n++) begin
            e1 = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                delta = int'(e1) + $urandom_range(0, 24) - 12;
                if (delta < 0) delta = 0;
                if (delta > 255) delta = 255;
                e2 = 8'(delta);
            end else begin
                e2 = 8'($urandom);
            end
            run_txn(e1, e2, rand_bcd(), rand_bcd(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
